iram_fetch_scheduler: RTL

IRAM_FETCH_SCHEDULER -- requirements
Module: iram_fetch_scheduler

---
 rtl/iram_fetch_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/iram_fetch_scheduler.sv
// rtl/iram_fetch_scheduler.sv - batched multi-core instruction fetch over a lane-parallel IRAM
// Optional out-of-range address trapping is enabled by defining IRAM_BOUNDS_CHECK_EN.
module iram_fetch_scheduler #(
  parameter int NUM_REQ   = 16,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 64
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          ReqVec,
  input  logic [NUM_REQ*ADDR_W-1:0]   AddrBus,
  output logic [NUM_REQ-1:0]          AckVec,
  output logic [NUM_REQ*DATA_W-1:0]   InstrData,
  output logic [NUM_REQ-1:0]          AddrErr,
  output logic                        Busy,
  output logic [15:0]                 FetchCount,
  output logic [1:0]                  MemControl,
  output logic [NUM_REQ*ADDR_W-1:0]   MemAddr,
  input  logic [NUM_REQ*DATA_W-1:0]   MemInstr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [NUM_REQ-1:0]          r_pending;
  logic [NUM_REQ-1:0]          r_ack;
  logic [NUM_REQ*ADDR_W-1:0]   r_addr;
  logic [NUM_REQ*DATA_W-1:0]   r_instr;
  logic [15:0]                 r_fetch_count;
  logic [1:0]                  w_mem_control;
  logic [NUM_REQ-1:0]          w_oob;
  logic [NUM_REQ*ADDR_W-1:0]   w_latch_addr;
  logic [NUM_REQ*ADDR_W-1:0]   w_mem_addr;
  logic [NUM_REQ*DATA_W-1:0]   w_capture;
`ifdef IRAM_BOUNDS_CHECK_EN
  logic [NUM_REQ-1:0]          r_err;
`endif

  always_comb begin
    w_next_state  = r_state;
    w_mem_control = 2'b00;
    case (r_state)
      ST_IDLE:    if (|ReqVec) w_next_state = ST_ISSUE;
      ST_ISSUE: begin
        w_mem_control = 2'b01;
        w_next_state  = ST_CAPTURE;
      end
      ST_CAPTURE: w_next_state = ST_RESP;
      ST_RESP:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Per-lane address latch, range trap and capture selection.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign w_latch_addr[gi*ADDR_W +: ADDR_W] = ReqVec[gi] ? AddrBus[gi*ADDR_W +: ADDR_W] : '0;
`ifdef IRAM_BOUNDS_CHECK_EN
    assign w_oob[gi] = (32'(r_addr[gi*ADDR_W +: ADDR_W]) >= MEM_DEPTH);
`else
    assign w_oob[gi] = 1'b0;
`endif
    assign w_mem_addr[gi*ADDR_W +: ADDR_W] = w_oob[gi] ? '0 : r_addr[gi*ADDR_W +: ADDR_W];
    assign w_capture[gi*DATA_W +: DATA_W]  = !r_pending[gi] ? r_instr[gi*DATA_W +: DATA_W] :
                                             w_oob[gi]      ? '0 :
                                                              MemInstr[gi*DATA_W +: DATA_W];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_pending     <= '0;
      r_addr        <= '0;
      r_ack         <= '0;
      r_instr       <= '0;
      r_fetch_count <= '0;
`ifdef IRAM_BOUNDS_CHECK_EN
      r_err         <= '0;
`endif
    end else begin
      r_state <= w_next_state;
      r_ack   <= '0;
`ifdef IRAM_BOUNDS_CHECK_EN
      r_err   <= '0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (|ReqVec) begin
            r_pending <= ReqVec;
            r_addr    <= w_latch_addr;
          end
        end
        ST_CAPTURE: begin
          r_instr <= w_capture;
          r_ack   <= r_pending;
`ifdef IRAM_BOUNDS_CHECK_EN
          r_err   <= r_pending & w_oob;
`endif
        end
        ST_RESP:  r_fetch_count <= r_fetch_count + 16'd1;
        default:  ;
      endcase
    end
  end

  assign AckVec     = r_ack;
  assign InstrData  = r_instr;
  assign Busy       = (r_state != ST_IDLE);
  assign FetchCount = r_fetch_count;
  assign MemControl = w_mem_control;
  assign MemAddr    = w_mem_addr;
`ifdef IRAM_BOUNDS_CHECK_EN
  assign AddrErr    = r_err;
`else
  assign AddrErr    = '0;
`endif

endmodule
